echo_unit: RTL and testbench
============================

Name: echo_unit

Overview:
- Feedback echo stage directly downstream of the dynamics stage.
- Consumes the dynamics stage's 16-bit signed sample and its one-cycle new-sample strobe.
- Adds an attenuated copy of its own output from DELAY_SAMPLES samples earlier, using a circular buffer in synchronous single-port RAM.
- Feeds the codec output path with a saturated sample plus a strobe.

Parameters:
- ADDR_W, 12: buffer address width; buffer depth is 2^ADDR_W words of 16 bits.
- DELAY_SAMPLES, 2400: echo delay in samples. Legal range is 2 to 2^ADDR_W.
- DECAY_SHIFT, 1: echo attenuation; the delayed sample is arithmetic-shifted right by this amount (0 to 15).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- sample_in  input  16  signed two's-complement sample from the dynamics stage
- new_sample_in  input  1  one-cycle strobe; sample_in is valid in this cycle
- enable  input  1  1 = echo mixed in; 0 = pass-through
- sample_out  output  16  signed output sample, held between updates
- new_sample_out  output  1  one-cycle strobe; sample_out is updated in this same cycle
- overrun  output  1  sticky flag: a strobe arrived while the block was busy

Behaviour:
- Reset (rst=1 at a clk edge):
  - sample_out=0, new_sample_out=0, overrun=0.
  - State=IDLE, write pointer=0, fill count=0.
  - An in-flight sample is aborted and produces no strobe.
  - RAM contents are not cleared.
- State machine, one transition per clk:
  - IDLE: on new_sample_in=1, capture sample_in into the input register, present the pointer address to the RAM read port, go to READ. Otherwise stay in IDLE.
  - READ: RAM data is valid at the end of this cycle; go to MIX.
  - MIX:
    - Compute the result and register it onto sample_out.
    - Write the stored value to RAM[pointer].
    - Advance the pointer, pulse new_sample_out, return to IDLE.
- Latency: a strobe at cycle t yields new_sample_out=1 at cycle t+3. Minimum strobe spacing is 3 cycles.
- Pointer:
  - Counts 0 to DELAY_SAMPLES-1, then wraps to 0.
  - Reading and writing the same address means the read returns the value written DELAY_SAMPLES samples earlier.
- Fill count:
  - Increments on each MIX and saturates at DELAY_SAMPLES.
  - While fill < DELAY_SAMPLES, the delayed value is forced to 0, so stale RAM is never heard.
- Arithmetic:
  - echo = delayed >>> DECAY_SHIFT (sign-preserving, rounds toward minus infinity; -1 >>> 1 = -1).
  - sum = sign-extended 17-bit sample_in + echo.
  - Result saturates: above 32767 becomes 32767; below -32768 becomes -32768.
- enable=1: sample_out = saturated sum. The RAM stores the same saturated sum, giving feedback.
- enable=0: sample_out = sample_in. The RAM stores sample_in.
  - Pointer and fill count still advance, so the echo resumes with correct history when re-enabled.
- enable is sampled in the MIX cycle only.
- Strobe handling while busy:
  - new_sample_in=1 while in READ or MIX is dropped and sets overrun=1.
  - overrun clears only on reset.
  - The in-flight sample completes normally.
- Simultaneous rst and new_sample_in: reset wins and the sample is discarded.

Test Plan (bench sets DELAY_SAMPLES=4, DECAY_SHIFT=1, ADDR_W=3; strobes every 8 cycles unless noted):
- Reset held 2 cycles, then idle -> sample_out=0, new_sample_out=0, overrun=0. The first strobe yields new_sample_out exactly 3 cycles later.
- enable=1, inputs 1000 followed by zeros -> outputs 1000,0,0,0,500,0,0,0,250,0,0,0,125; the first four outputs carry no contribution from stale RAM.
- enable=1, constant input 30000 -> outputs 30000 ×4, then 32767 thereafter. Constant input -30000 -> -30000 ×4, then -32768.
- enable=0, inputs 1000, -5, 32767, -32768 -> identical values out, each 3 cycles after its strobe. Switching to enable=1 with zero input -> the 5th output is 500.
- Strobes at cycles t and t+1 -> a single output at t+3 carrying the first sample; overrun=1 from t+2 and held until rst.
- Impulse 1000, then rst asserted during its READ cycle -> no new_sample_out. A subsequent input of 0 produces 0 ×8 with no echo of the 1000.

Source files
------------

// File: rtl/echo_unit.sv
// Feedback echo stage: mixes an attenuated copy of its own output from DELAY_SAMPLES
// samples ago into each new sample, using a circular buffer in single-port RAM.
module echo_unit #(
    parameter int ADDR_W        = 12,
    parameter int DELAY_SAMPLES = 2400,
    parameter int DECAY_SHIFT   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] sample_in,
    input  logic               new_sample_in,
    input  logic               enable,
    output logic signed [15:0] sample_out,
    output logic               new_sample_out,
    output logic               overrun,
    output logic [1:0]         dbg_state
);

    // Handshake: new_sample_in is a one-cycle strobe accepted only in S_IDLE;
    // new_sample_out pulses for one cycle in the same cycle sample_out takes its new value.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_MIX  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LP_PTR_LAST  = ADDR_W'(DELAY_SAMPLES - 1);
    localparam logic [ADDR_W:0]   LP_FILL_FULL = (ADDR_W + 1)'(DELAY_SAMPLES);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_ptr;
    logic [ADDR_W:0]    r_fill;
    logic signed [15:0] r_in;
    logic signed [15:0] r_rdata;
    logic signed [15:0] r_sample_out;
    logic               r_new_sample_out;
    logic               r_overrun;
    logic signed [15:0] r_mem [0:(1 << ADDR_W) - 1];

    logic signed [15:0] w_delayed;
    logic signed [15:0] w_echo;
    logic signed [16:0] w_sum;
    logic signed [15:0] w_mix;
    logic signed [15:0] w_store;
    logic               w_we;

    // Until the buffer has been written once all the way round, RAM holds stale data.
    always_comb begin
        w_delayed = (r_fill == LP_FILL_FULL) ? r_rdata : 16'sd0;
        w_echo    = w_delayed >>> DECAY_SHIFT;
        w_sum     = {r_in[15], r_in} + {w_echo[15], w_echo};
        if (w_sum[16] != w_sum[15]) begin
            w_mix = w_sum[16] ? 16'sh8000 : 16'sh7fff;
        end else begin
            w_mix = w_sum[15:0];
        end
        w_store = enable ? w_mix : r_in;
        w_we    = (r_state == S_MIX);
    end

    // Single-port RAM: the pointer is the only address; it is stable from IDLE through MIX.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_ptr] <= w_store;
        end
        r_rdata <= r_mem[r_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= S_IDLE;
            r_ptr            <= '0;
            r_fill           <= '0;
            r_in             <= '0;
            r_sample_out     <= '0;
            r_new_sample_out <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_new_sample_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (new_sample_in) begin
                        r_in    <= sample_in;
                        r_state <= S_READ;
                    end
                end
                S_READ: begin
                    if (new_sample_in) begin
                        r_overrun <= 1'b1;
                    end
                    r_state <= S_MIX;
                end
                S_MIX: begin
                    if (new_sample_in) begin
                        r_overrun <= 1'b1;
                    end
                    r_sample_out     <= w_store;
                    r_new_sample_out <= 1'b1;
                    r_ptr            <= (r_ptr == LP_PTR_LAST) ? '0 : r_ptr + 1'b1;
                    if (r_fill != LP_FILL_FULL) begin
                        r_fill <= r_fill + 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sample_out     = r_sample_out;
    assign new_sample_out = r_new_sample_out;
    assign overrun        = r_overrun;
    assign dbg_state      = r_state;

endmodule

// File: tb/tb_echo_unit.sv
// Bench for echo_unit with a 4-sample delay: a queue-based reference model feeds a
// scoreboard that checks every output value and its strobe latency.
module tb_echo_unit;

    localparam int DELAY = 4;
    localparam int SHIFT = 1;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] sample_in = '0;
    logic               new_sample_in = 1'b0;
    logic               enable = 1'b0;
    logic signed [15:0] sample_out;
    logic               new_sample_out;
    logic               overrun;
    logic [1:0]         dbg_state;

    echo_unit #(
        .ADDR_W(3),
        .DELAY_SAMPLES(DELAY),
        .DECAY_SHIFT(SHIFT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sample_in(sample_in),
        .new_sample_in(new_sample_in),
        .enable(enable),
        .sample_out(sample_out),
        .new_sample_out(new_sample_out),
        .overrun(overrun),
        .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0]        exp_q[$];
    int                 exp_cyc_q[$];
    logic signed [15:0] hist[$];
    int                 total = 0;
    int                 bad = 0;
    int                 strobe_cnt = 0;
    logic [15:0]        mon_e;
    int                 mon_c;

    // Reference model: hist holds the last DELAY stored values, oldest first.
    function automatic logic signed [15:0] model_step(input logic signed [15:0] s, input logic en);
        int d;
        int sum;
        logic signed [15:0] res;
        d = 0;
        if (hist.size() == DELAY) d = hist.pop_front();
        sum = int'(s) + (d >>> SHIFT);
        if (sum > 32767) res = 16'sh7fff;
        else if (sum < -32768) res = 16'sh8000;
        else res = 16'(sum);
        if (!en) res = s;
        hist.push_back(res);
        return res;
    endfunction

    always @(negedge clk) begin
        if (new_sample_out === 1'b1) begin
            strobe_cnt++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_strobe cyc=%0d got=%0d expected=no strobe", cyc, sample_out);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                if (sample_out !== mon_e) begin
                    bad++;
                    $display("FAIL sample_value cyc=%0d got=%0d expected=%0d", cyc, sample_out, $signed(mon_e));
                end
                total++;
                if (cyc !== mon_c + 3) begin
                    bad++;
                    $display("FAIL strobe_latency got_cyc=%0d expected_cyc=%0d", cyc, mon_c + 3);
                end
            end
        end
    end

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 rst = 1'b1;
        new_sample_in = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic send(input logic signed [15:0] s, input int gap);
        @(posedge clk);
        #1 sample_in = s;
        new_sample_in = 1'b1;
        exp_q.push_back(model_step(s, enable));
        exp_cyc_q.push_back(cyc);
        @(posedge clk);
        #1 new_sample_in = 1'b0;
        repeat (gap - 2) @(posedge clk);
    endtask

    task automatic test_reset;
        do_reset(2);
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (sample_out !== 16'sd0) begin
            bad++;
            $display("FAIL reset_sample_out got=%0d expected=0", sample_out);
        end
        total++;
        if (new_sample_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_strobe got=%0b expected=0", new_sample_out);
        end
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL reset_overrun got=%0b expected=0", overrun);
        end
        total++;
        if (dbg_state !== 2'd0) begin
            bad++;
            $display("FAIL reset_state got=%0d expected=0", dbg_state);
        end
        enable = 1'b0;
        send(16'sd1234, 8);
    endtask

    task automatic test_saturate;
        do_reset(2);
        enable = 1'b1;
        for (int i = 0; i < 8; i++) send(16'sd30000, 8);
        do_reset(2);
        for (int i = 0; i < 8; i++) send(-16'sd30000, 8);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL saturate_drain got=%0d expected=0 pending", exp_q.size());
        end
    endtask

    task automatic test_impulse;
        do_reset(2);
        enable = 1'b1;
        send(16'sd1000, 8);
        for (int i = 0; i < 12; i++) send(16'sd0, 8);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL impulse_drain got=%0d expected=0 pending", exp_q.size());
        end
    endtask

    task automatic test_passthrough;
        logic signed [15:0] vals [4];
        vals = '{16'sd1000, -16'sd5, 16'sd32767, -16'sd32768};
        do_reset(2);
        enable = 1'b0;
        for (int i = 0; i < 4; i++) send(vals[i], 8);
        enable = 1'b1;
        for (int i = 0; i < 4; i++) send(16'sd0, 8);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL passthrough_drain got=%0d expected=0 pending", exp_q.size());
        end
    endtask

    task automatic test_back_to_back;
        do_reset(2);
        enable = 1'b1;
        @(posedge clk);
        #1 sample_in = 16'sd777;
        new_sample_in = 1'b1;
        exp_q.push_back(model_step(16'sd777, enable));
        exp_cyc_q.push_back(cyc);
        @(posedge clk);
        #1 sample_in = 16'sd888;
        @(negedge clk);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_early got=%0b expected=0", overrun);
        end
        @(posedge clk);
        #1 new_sample_in = 1'b0;
        @(negedge clk);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_set got=%0b expected=1", overrun);
        end
        repeat (6) @(posedge clk);
        send(16'sd10, 8);
        send(16'sd20, 8);
        @(negedge clk);
        total++;
        if (overrun !== 1'b1) begin
            bad++;
            $display("FAIL overrun_sticky got=%0b expected=1", overrun);
        end
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL back_to_back_drain got=%0d expected=0 pending", exp_q.size());
        end
        do_reset(1);
        @(negedge clk);
        total++;
        if (overrun !== 1'b0) begin
            bad++;
            $display("FAIL overrun_clear got=%0b expected=0", overrun);
        end
    endtask

    task automatic test_reset_abort;
        int cnt0;
        do_reset(2);
        enable = 1'b1;
        cnt0 = strobe_cnt;
        @(posedge clk);
        #1 sample_in = 16'sd1000;
        new_sample_in = 1'b1;
        @(posedge clk);
        #1 new_sample_in = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        hist.delete();
        repeat (6) @(posedge clk);
        total++;
        if (strobe_cnt !== cnt0) begin
            bad++;
            $display("FAIL abort_no_strobe got=%0d expected=%0d", strobe_cnt, cnt0);
        end
        for (int i = 0; i < 8; i++) send(16'sd0, 8);
        total++;
        if (strobe_cnt !== cnt0 + 8) begin
            bad++;
            $display("FAIL abort_followup_count got=%0d expected=%0d", strobe_cnt, cnt0 + 8);
        end
    endtask

    initial begin
        test_reset;
        test_saturate;
        test_impulse;
        test_passthrough;
        test_back_to_back;
        test_reset_abort;
        repeat (4) @(posedge clk);
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL final_drain got=%0d expected=0 pending", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
